// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ requesters,
// with a watchdog that releases the grant if the transmitter never reports done.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*DBIT-1:0] i_data,
  input  logic                 i_tx_done_tick,
  output logic                 o_tx_start,
  output logic [DBIT-1:0]      o_tx_din,
  output logic [NREQ-1:0]      o_gnt,
  output logic [NREQ-1:0]      o_ack,
  output logic                 o_err,
  output logic                 o_busy
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   last, last_n;
  logic [IW-1:0]   owner, owner_n;
  logic [NREQ-1:0] gnt, gnt_n;
  logic [NREQ-1:0] ack, ack_n;
  logic [DBIT-1:0] din, din_n;
  logic [15:0]     wd, wd_n;
  logic            err, err_n;

  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic            found;
  logic            expire;

  // First pending requester at or after last+1, wrapping.
  always_comb begin
    win   = last;
    idx   = last;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!found && i_req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // The START cycle counts toward the limit, so the release lands TIMEOUT cycles after START.
  assign expire = (int'(wd) + 2) >= TIMEOUT;

  always_comb begin
    state_n = state;
    last_n  = last;
    owner_n = owner;
    gnt_n   = gnt;
    din_n   = din;
    wd_n    = wd;
    ack_n   = '0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (|i_req) begin
          state_n = START;
          owner_n = win;
          gnt_n   = NREQ'(1) << win;
          din_n   = i_data[int'(win)*DBIT +: DBIT];
        end
      end
      START: begin
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (i_tx_done_tick) begin
          state_n = RELEASE;
          ack_n   = gnt;
        end else if (expire) begin
          state_n = RELEASE;
          err_n   = 1'b1;
        end else begin
          wd_n = wd + 16'd1;
        end
      end
      RELEASE: begin
        gnt_n   = '0;
        last_n  = owner;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      last  <= IW'(NREQ - 1);
      owner <= '0;
      gnt   <= '0;
      ack   <= '0;
      din   <= '0;
      wd    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      last  <= last_n;
      owner <= owner_n;
      gnt   <= gnt_n;
      ack   <= ack_n;
      din   <= din_n;
      wd    <= wd_n;
      err   <= err_n;
    end
  end

  assign o_tx_start = (state == START);
  assign o_tx_din   = din;
  assign o_gnt      = gnt;
  assign o_ack      = ack;
  assign o_err      = err;
  assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand sequences for reset and
// idle corner cases, then randomized transfers checked against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int TO   = 10;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic        i_tx_done_tick;
  logic        o_tx_start;
  logic [7:0]  o_tx_din;
  logic [3:0]  o_gnt;
  logic [3:0]  o_ack;
  logic        o_err;
  logic        o_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .TIMEOUT(TO)) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_req          (i_req),
    .i_data         (i_data),
    .i_tx_done_tick (i_tx_done_tick),
    .o_tx_start     (o_tx_start),
    .o_tx_din       (o_tx_din),
    .o_gnt          (o_gnt),
    .o_ack          (o_ack),
    .o_err          (o_err),
    .o_busy         (o_busy)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         model_last;
  logic [7:0] model_din;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [31:0] data;
    int          dly;
    int          win;
    logic        ack;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first set bit at or after (last+1) mod NREQ.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (r[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  // Called at the negedge of an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic do_txn(input logic [3:0] req, input logic [31:0] data, input int dly,
                        input int exp_win, input logic exp_ack, input bit wiggle);
    logic [3:0] oh;
    logic [7:0] b;
    int         rel;
    oh  = 4'b0001 << exp_win;
    b   = data[exp_win*8 +: 8];
    rel = exp_ack ? dly + 1 : TO;
    chk("idle_busy", 32'(o_busy), 32'd0);
    i_req = req;
    i_data = data;
    i_tx_done_tick = 1'b0;
    @(negedge clk);
    chk("start_pulse", 32'(o_tx_start), 32'd1);
    chk("start_gnt", 32'(o_gnt), 32'(oh));
    chk("start_din", 32'(o_tx_din), 32'(b));
    i_data = $urandom;
    if (wiggle) i_req = 4'($urandom);
    for (int c = 1; c <= rel; c++) begin
      @(negedge clk);
      if (c < rel) begin
        chk("wait_start_low", 32'(o_tx_start), 32'd0);
        chk("wait_quiet", {o_ack, o_err}, 32'd0);
        chk("wait_gnt", 32'(o_gnt), 32'(oh));
        chk("wait_din", 32'(o_tx_din), 32'(b));
        i_tx_done_tick = (c == dly);
        i_data = $urandom;
        if (wiggle) i_req = 4'($urandom);
      end else begin
        chk("rel_ack", 32'(o_ack), exp_ack ? 32'(oh) : 32'd0);
        chk("rel_err", 32'(o_err), exp_ack ? 32'd0 : 32'd1);
        chk("rel_busy", 32'(o_busy), 32'd1);
        chk("rel_din", 32'(o_tx_din), 32'(b));
        i_tx_done_tick = 1'b0;
        i_req = 4'b0000;
      end
    end
    @(negedge clk);
    chk("post_busy", 32'(o_busy), 32'd0);
    chk("post_gnt", 32'(o_gnt), 32'd0);
    chk("post_pulses", {o_ack, o_err, o_tx_start}, 32'd0);
    chk("post_din", 32'(o_tx_din), 32'(b));
    model_last = exp_win;
    model_din  = b;
  endtask

  // Called at a negedge; holds reset over one rising edge and checks the reset values.
  task automatic do_reset(input logic tick);
    i_reset = 1'b1;
    i_req = 4'b0000;
    i_tx_done_tick = tick;
    @(negedge clk);
    chk("rst_start", 32'(o_tx_start), 32'd0);
    chk("rst_din", 32'(o_tx_din), 32'd0);
    chk("rst_gnt", 32'(o_gnt), 32'd0);
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    i_reset = 1'b0;
    i_tx_done_tick = 1'b0;
    model_last = NREQ - 1;
    model_din  = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  r;
    logic [31:0] rd;
    int          d;
    int          w;
    logic        a;

    vt[0] = '{1'b1, 4'b0001, 32'h0000_0055, 3, 0, 1'b1};
    vt[1] = '{1'b1, 4'b1111, 32'hA3A2_A1A0, 2, 0, 1'b1};
    vt[2] = '{1'b0, 4'b1111, 32'hA3A2_A1A0, 2, 1, 1'b1};
    vt[3] = '{1'b0, 4'b1111, 32'hA3A2_A1A0, 2, 2, 1'b1};
    vt[4] = '{1'b0, 4'b1111, 32'hA3A2_A1A0, 2, 3, 1'b1};
    vt[5] = '{1'b0, 4'b1111, 32'hA3A2_A1A0, 2, 0, 1'b1};
    vt[6] = '{1'b0, 4'b0010, 32'h0000_3C00, 0, 1, 1'b0};
    vt[7] = '{1'b0, 4'b0100, 32'h00E7_0000, TO - 1, 2, 1'b1};
    vt[8] = '{1'b0, 4'b1001, 32'h9900_0011, 1, 3, 1'b1};
    vt[9] = '{1'b0, 4'b1001, 32'h9900_0011, 4, 0, 1'b1};

    i_reset = 1'b1;
    i_req = 4'b0000;
    i_data = 32'h0;
    i_tx_done_tick = 1'b0;
    do_reset(1'b0);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].rst) do_reset(1'b0);
      do_txn(vt[i].req, vt[i].data, vt[i].dly, vt[i].win, vt[i].ack, 1'b0);
    end

    // Done ticks while idle must not start anything or disturb the held byte.
    i_req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      i_tx_done_tick = 1'b1;
      i_data = $urandom;
      @(negedge clk);
      chk("idle_tick_busy", 32'(o_busy), 32'd0);
      chk("idle_tick_out", {o_gnt, o_ack, o_err, o_tx_start}, 32'd0);
      chk("idle_tick_din", 32'(o_tx_din), 32'(model_din));
    end
    i_tx_done_tick = 1'b0;

    // Reset in the middle of WAIT, with a done tick on the same edge.
    i_req = 4'b0010;
    i_data = 32'h0000_7700;
    @(negedge clk);
    chk("mid_start", 32'(o_tx_start), 32'd1);
    i_req = 4'b0000;
    @(negedge clk);
    chk("mid_wait_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    do_reset(1'b1);
    do_txn(4'b0100, 32'h0042_0000, 3, rr_pick(4'b0100, model_last), 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r  = 4'($urandom_range(1, 15));
      rd = $urandom;
      d  = $urandom_range(0, 12);
      w  = rr_pick(r, model_last);
      a  = (d >= 1) && (d <= TO - 1);
      do_txn(r, rd, d, w, a, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        i_req = 4'b0000;
        @(negedge clk);
        chk("gap_idle", 32'(o_busy), 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter DBIT, default 8, SHALL set the data byte width.
REQ-003 Parameter TIMEOUT, default 65535, SHALL set the WAIT-state watchdog limit in i_clk cycles (1..65535).
REQ-004 i_clk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 i_reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 i_req  in  NREQ  SHALL carry per-requester transmit requests, level-sensitive.
REQ-007 i_data  in  NREQ*DBIT  SHALL carry the byte for requester k in bits [k*DBIT +: DBIT].
REQ-008 i_tx_done_tick  in  1  SHALL be the one-cycle completion pulse from the transmitter.
REQ-009 o_tx_start  out  1  SHALL be the one-cycle start pulse to the transmitter.
REQ-010 o_tx_din  out  DBIT  SHALL be the byte presented to the transmitter.
REQ-011 o_gnt  out  NREQ  SHALL be a one-hot grant, held from the grant decision until release.
REQ-012 o_ack  out  NREQ  SHALL be a one-cycle, one-hot completion pulse to the owner.
REQ-013 o_err  out  1  SHALL be a one-cycle pulse on watchdog expiry.
REQ-014 o_busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, START, WAIT and RELEASE.
REQ-016 In IDLE with i_req != 0, the next state SHALL be START; the arbiter SHALL select the winner and latch its i_data into o_tx_din; o_gnt SHALL take the winner one-hot.
REQ-017 Winner selection SHALL be round-robin: first set i_req bit at or after index (last+1) mod NREQ; last resets to NREQ-1, so requester 0 has priority after reset.
REQ-018 In IDLE with i_req == 0, state, o_gnt and o_tx_din SHALL hold.
REQ-019 In START, o_tx_start SHALL be 1 for exactly one cycle; the next state SHALL be WAIT; the watchdog counter SHALL clear.
REQ-020 o_tx_start SHALL rise one cycle after the IDLE cycle in which a request is sampled.
REQ-021 o_tx_din SHALL stay stable from latch until the cycle after RELEASE, regardless of i_data changes.
REQ-022 In WAIT, an i_tx_done_tick SHALL cause a transition to RELEASE and pulse o_ack[owner] in the RELEASE cycle.
REQ-023 In WAIT, the watchdog SHALL increment every cycle without i_tx_done_tick; on reaching TIMEOUT it SHALL go to RELEASE, pulse o_err, and SHALL NOT pulse o_ack.
REQ-024 If i_tx_done_tick and the watchdog limit coincide, done SHALL win: o_ack pulses and o_err does not.
REQ-025 RELEASE SHALL last one cycle: o_gnt clears to 0, last takes the owner index, and the next state SHALL be IDLE.
REQ-026 i_tx_done_tick outside WAIT SHALL be ignored.
REQ-027 Deassertion of i_req[owner] during START or WAIT SHALL NOT abort the transfer; the ack still pulses.
REQ-028 A requester holding i_req after its ack SHALL be re-granted only after all other pending requesters are served.
REQ-029 Minimum spacing between consecutive o_tx_start pulses SHALL be 3 cycles plus the transmitter frame time.

Reset
REQ-030 While i_reset is high at a clock edge, the state SHALL go to IDLE and last to NREQ-1.
REQ-031 On reset, outputs SHALL be: o_tx_start=0, o_tx_din=0, o_gnt=0, o_ack=0, o_err=0, o_busy=0; the watchdog counter SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL drop the grant with no o_ack or o_err pulse.

Verification
REQ-033 Reset, then i_req=4'b0001 with byte 0x55 -> o_tx_start one cycle later with o_tx_din=0x55 and o_gnt=0001; done tick -> o_ack=0001 for one cycle, then o_gnt=0.
REQ-034 i_req=4'b1111 held with bytes 0xA0..0xA3 -> grants in order 0,1,2,3,0, with o_tx_din following the matching byte each time.
REQ-035 TIMEOUT=10, no done tick -> o_err pulses once, 10 cycles after START; no o_ack; back in IDLE 1 cycle later.
REQ-036 Done tick on the same cycle the watchdog reaches TIMEOUT -> o_ack pulses and o_err stays 0.
REQ-037 i_reset asserted during WAIT -> all outputs at reset values next cycle; a following i_req=4'b0100 is granted to requester 2.
REQ-038 Done tick injected in IDLE, and i_data changed during WAIT -> no state change in IDLE, and o_tx_din unchanged during WAIT.
